// File: rtl/vec_alu_seq.sv
// vec_alu_seq: runs one MSA vector ALU op through the shared SLICE-bit ALU,
// one slice per granted beat, and assembles the VLEN-bit result.
module vec_alu_seq #(
    parameter int VLEN  = 128,
    parameter int SLICE = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       vop,
    input  logic [1:0]       df,
    input  logic [VLEN-1:0]  src_a,
    input  logic [VLEN-1:0]  src_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [VLEN-1:0]  result,
    output logic             alu_req,
    input  logic             alu_gnt,
    output logic [SLICE-1:0] alu_a,
    output logic [SLICE-1:0] alu_b,
    output logic [2:0]       alu_ctrl,
    output logic [1:0]       alu_df,
    input  logic [SLICE-1:0] alu_result
);

    localparam int BEATS = VLEN / SLICE;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [BW-1:0] BEAT_ONE  = BW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    function automatic logic op_legal(input logic [2:0] op, input logic [1:0] fmt);
        logic ok;
        case (op)
            3'b000, 3'b001, 3'b010, 3'b011, 3'b100: ok = (fmt != 2'b11);
            default:                                ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [2:0] op_ctrl(input logic [2:0] op);
        logic [2:0] c;
        case (op)
            3'b000:  c = 3'b000;
            3'b001:  c = 3'b001;
            3'b010:  c = 3'b010;
            3'b011:  c = 3'b011;
            3'b100:  c = 3'b100;
            default: c = 3'b000;
        endcase
        return c;
    endfunction

    state_t            r_state;
    state_t            w_next;
    logic [BW-1:0]     r_beat;
    logic [BW-1:0]     w_beat_next;
    logic [VLEN-1:0]   r_op_a;
    logic [VLEN-1:0]   r_op_b;
    logic [2:0]        r_ctrl;
    logic [1:0]        r_df;
    logic [VLEN-1:0]   r_result;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic              r_alu_req;
    logic              w_accept;
    logic              w_illegal;
    logic              w_capture;
    logic [SLICE-1:0]  w_alu_a;
    logic [SLICE-1:0]  w_alu_b;
    logic [2:0]        w_alu_ctrl;
    logic [1:0]        w_alu_df;

    // Next-state and beat sequencing; flush outranks start in IDLE
    always_comb begin
        w_next      = r_state;
        w_beat_next = r_beat;
        w_accept    = 1'b0;
        w_illegal   = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (flush) begin
                    w_next = S_IDLE;
                end else if (start) begin
                    if (op_legal(vop, df)) begin
                        w_accept    = 1'b1;
                        w_next      = S_RUN;
                        w_beat_next = {BW{1'b0}};
                    end else begin
                        w_illegal = 1'b1;
                        w_next    = S_DONE;
                    end
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_RUN: begin
                if (flush) begin
                    w_next      = S_IDLE;
                    w_beat_next = {BW{1'b0}};
                end else if (alu_gnt) begin
                    w_capture = 1'b1;
                    if (r_beat == LAST_BEAT) begin
                        w_next = S_DONE;
                    end else begin
                        w_beat_next = r_beat + BEAT_ONE;
                    end
                end else begin
                    w_next = S_RUN;
                end
            end
            S_DONE: begin
                w_next      = S_IDLE;
                w_beat_next = {BW{1'b0}};
            end
            default: begin
                w_next      = S_IDLE;
                w_beat_next = {BW{1'b0}};
            end
        endcase
    end

    // State, beat counter and registered status flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_beat    <= {BW{1'b0}};
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_alu_req <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_beat    <= w_beat_next;
            r_busy    <= (w_next != S_IDLE);
            r_done    <= (w_next == S_DONE);
            r_err     <= w_illegal;
            r_alu_req <= (w_next == S_RUN);
        end
    end

    // Operand and decoded-op latch, loaded only by an accepted legal start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op_a <= {VLEN{1'b0}};
            r_op_b <= {VLEN{1'b0}};
            r_ctrl <= 3'b000;
            r_df   <= 2'b00;
        end else if (w_accept) begin
            r_op_a <= src_a;
            r_op_b <= src_b;
            r_ctrl <= op_ctrl(vop);
            r_df   <= df;
        end else begin
            r_op_a <= r_op_a;
            r_op_b <= r_op_b;
            r_ctrl <= r_ctrl;
            r_df   <= r_df;
        end
    end

    // Result assembly: cleared on any start taken in IDLE, one slice per grant
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_result <= {VLEN{1'b0}};
        end else if (w_accept || w_illegal) begin
            r_result <= {VLEN{1'b0}};
        end else if (w_capture) begin
            r_result[r_beat*SLICE +: SLICE] <= alu_result;
        end else begin
            r_result <= r_result;
        end
    end

    // ALU-side drive, forced to zero whenever no request is outstanding
    always_comb begin
        w_alu_a    = {SLICE{1'b0}};
        w_alu_b    = {SLICE{1'b0}};
        w_alu_ctrl = 3'b000;
        w_alu_df   = 2'b00;
        if (r_alu_req) begin
            w_alu_a    = r_op_a[r_beat*SLICE +: SLICE];
            w_alu_b    = r_op_b[r_beat*SLICE +: SLICE];
            w_alu_ctrl = r_ctrl;
            w_alu_df   = r_df;
        end else begin
            w_alu_a    = {SLICE{1'b0}};
            w_alu_b    = {SLICE{1'b0}};
            w_alu_ctrl = 3'b000;
            w_alu_df   = 2'b00;
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;
    assign result   = r_result;
    assign alu_req  = r_alu_req;
    assign alu_a    = w_alu_a;
    assign alu_b    = w_alu_b;
    assign alu_ctrl = w_alu_ctrl;
    assign alu_df   = w_alu_df;

endmodule

// File: tb/tb_vec_alu_seq.sv
// Bench for vec_alu_seq: the bench plays the shared ALU and keeps an
// element-level reference of the whole instruction to compare every cycle.
module tb_vec_alu_seq;

    localparam int VLEN  = 128;
    localparam int SLICE = 32;
    localparam int BEATS = VLEN / SLICE;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [2:0]       vop;
    logic [1:0]       df;
    logic [VLEN-1:0]  src_a;
    logic [VLEN-1:0]  src_b;
    logic             flush;
    logic             busy;
    logic             done;
    logic             err;
    logic [VLEN-1:0]  result;
    logic             alu_req;
    logic             alu_gnt;
    logic [SLICE-1:0] alu_a;
    logic [SLICE-1:0] alu_b;
    logic [2:0]       alu_ctrl;
    logic [1:0]       alu_df;
    logic [SLICE-1:0] alu_result;
    logic [VLEN-1:0]  alu_wide;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    vec_alu_seq #(.VLEN(VLEN), .SLICE(SLICE)) dut (
        .clk(clk), .reset(reset), .start(start), .vop(vop), .df(df),
        .src_a(src_a), .src_b(src_b), .flush(flush), .busy(busy), .done(done),
        .err(err), .result(result), .alu_req(alu_req), .alu_gnt(alu_gnt),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_df(alu_df),
        .alu_result(alu_result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Element-wise MSA op on a whole vector; illegal op/format yields zero
    function automatic logic [VLEN-1:0] vec_op(input logic [VLEN-1:0] a, input logic [VLEN-1:0] b,
                                               input logic [2:0] op, input logic [1:0] fmt);
        logic [VLEN-1:0] r;
        longint unsigned ea, eb, er, mask;
        longint sa, sb;
        int ew;
        r = '0;
        if (fmt == 2'b11 || op > 3'd4) return r;
        ew = 8 << fmt;
        mask = (64'd1 << ew) - 64'd1;
        for (int i = 0; i < VLEN / ew; i++) begin
            ea = 64'(a >> (i * ew)) & mask;
            eb = 64'(b >> (i * ew)) & mask;
            sa = longint'(ea);
            sb = longint'(eb);
            if (ea[ew-1]) sa = sa - (longint'(1) << ew);
            if (eb[ew-1]) sb = sb - (longint'(1) << ew);
            case (op)
                3'd0:    er = ea + eb;
                3'd1:    er = ea - eb;
                3'd2:    er = ea & eb;
                3'd3:    er = ea | eb;
                3'd4:    er = (sa < sb) ? 64'd1 : 64'd0;
                default: er = 64'd0;
            endcase
            r = r | (VLEN'(er & mask) << (i * ew));
        end
        return r;
    endfunction

    assign alu_wide   = vec_op({{(VLEN-SLICE){1'b0}}, alu_a}, {{(VLEN-SLICE){1'b0}}, alu_b}, alu_ctrl, alu_df);
    assign alu_result = alu_wide[SLICE-1:0];

    task automatic chk(input string name, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: instruction-level phase, beats granted so far, whole-vector answer
    int              m_phase;
    int              m_k;
    logic            m_err;
    logic            m_res_valid;
    logic [VLEN-1:0] m_a, m_b, m_final;
    logic [2:0]      m_op;
    logic [1:0]      m_df;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase <= 0; m_k <= 0; m_err <= 1'b0; m_res_valid <= 1'b1;
            m_a <= '0; m_b <= '0; m_final <= '0; m_op <= 3'd0; m_df <= 2'd0;
        end else begin
            case (m_phase)
                0: if (!flush && start) begin
                    m_res_valid <= 1'b1;
                    if (vop <= 3'd4 && df != 2'b11) begin
                        m_phase <= 1; m_k <= 0; m_err <= 1'b0;
                        m_a <= src_a; m_b <= src_b; m_op <= vop; m_df <= df;
                        m_final <= vec_op(src_a, src_b, vop, df);
                    end else begin
                        m_phase <= 2; m_err <= 1'b1; m_final <= '0;
                    end
                end
                1: if (flush) begin
                    m_phase <= 0; m_k <= 0; m_res_valid <= 1'b0;
                end else if (alu_gnt) begin
                    m_k <= m_k + 1;
                    if (m_k == BEATS - 1) m_phase <= 2;
                end
                default: begin
                    m_phase <= 0; m_err <= 1'b0;
                end
            endcase
        end
    end

    logic [VLEN-1:0]  cmp_mask;
    logic [SLICE-1:0] exp_a, exp_b;

    // Per-cycle comparison of every DUT output against the reference
    always @(negedge clk) begin
        cmp_mask = (m_phase == 1) ? ({VLEN{1'b1}} >> (VLEN - m_k * SLICE)) : {VLEN{1'b1}};
        exp_a = '0;
        exp_b = '0;
        if (m_phase == 1) begin
            exp_a = m_a[m_k*SLICE +: SLICE];
            exp_b = m_b[m_k*SLICE +: SLICE];
        end
        chk("busy", VLEN'(busy), VLEN'(m_phase != 0));
        chk("done", VLEN'(done), VLEN'(m_phase == 2));
        chk("err", VLEN'(err), VLEN'(m_phase == 2 && m_err));
        chk("alu_req", VLEN'(alu_req), VLEN'(m_phase == 1));
        chk("alu_a", VLEN'(alu_a), VLEN'(exp_a));
        chk("alu_b", VLEN'(alu_b), VLEN'(exp_b));
        chk("alu_ctrl", VLEN'(alu_ctrl), VLEN'((m_phase == 1) ? m_op : 3'd0));
        chk("alu_df", VLEN'(alu_df), VLEN'((m_phase == 1) ? m_df : 2'd0));
        if (m_res_valid) chk("result", result, m_final & cmp_mask);
    end

    // Grant driver: random, or scripted stall cycles per beat
    int gnt_mode = 0;
    int stall_plan[BEATS];
    int stall_used[BEATS];
    initial begin
        alu_gnt = 1'b1;
        forever begin
            @(negedge clk);
            #1;
            if (gnt_mode == 1)
                alu_gnt = ($urandom_range(0, 3) != 0);
            else if (m_phase == 1 && m_k < BEATS && stall_used[m_k] < stall_plan[m_k]) begin
                alu_gnt = 1'b0;
                stall_used[m_k]++;
            end else
                alu_gnt = 1'b1;
        end
    end

    task automatic issue(input logic [2:0] op, input logic [1:0] fmt,
                         input logic [VLEN-1:0] a, input logic [VLEN-1:0] b, output int s);
        @(negedge clk);
        #1;
        start = 1'b1; vop = op; df = fmt; src_a = a; src_b = b;
        s = cyc;
    endtask

    task automatic wait_done(input int s, output int lat, output int dcyc, output int reqs, output logic err_seen);
        bit seen;
        seen = 0; lat = 0; dcyc = 0; reqs = 0; err_seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1; lat = cyc - s; dcyc = cyc; err_seen = err;
            end else if (alu_req === 1'b1) begin
                reqs++;
            end
            #1 start = 1'b0;
            if (seen) break;
        end
    endtask

    int s, lat, dcyc, reqs, d1;
    logic e;
    logic [VLEN-1:0] ra, rb;
    logic [2:0] rop;
    logic [1:0] rfmt;
    bit found;

    initial begin
        reset = 1'b1; start = 1'b0; flush = 1'b0; vop = 3'd0; df = 2'd0;
        src_a = '0; src_b = '0;
        for (int i = 0; i < BEATS; i++) begin stall_plan[i] = 0; stall_used[i] = 0; end
        repeat (2) @(negedge clk);
        chk("rst_busy", VLEN'(busy), VLEN'(0));
        chk("rst_result", result, '0);
        chk("rst_req", VLEN'(alu_req), VLEN'(0));
        #1 reset = 1'b0;

        // Model pins against hand-computed values
        chk("pin_addv", vec_op({32'd4, 32'd3, 32'd2, 32'd1}, {32'd10, 32'd20, 32'd30, 32'd40}, 3'd0, 2'd2),
            128'h0000000E_00000017_00000020_00000029);
        chk("pin_sltv_b", vec_op(128'hFF01, 128'h0102, 3'd4, 2'd0), 128'h0101);
        chk("pin_subv_h", vec_op(128'h0, 128'h1, 3'd1, 2'd1), 128'hFFFF);

        // addv word, continuous grant
        issue(3'd0, 2'd2, {32'd4, 32'd3, 32'd2, 32'd1}, {32'd10, 32'd20, 32'd30, 32'd40}, s);
        wait_done(s, lat, dcyc, reqs, e);
        chk("addv_lat", VLEN'(lat), VLEN'(BEATS + 1));
        chk("addv_reqs", VLEN'(reqs), VLEN'(BEATS));
        chk("addv_err", VLEN'(e), VLEN'(0));
        chk("addv_res", result, 128'h0000000E_00000017_00000020_00000029);

        // subv word with three-cycle stalls on beats 1 and 2
        stall_plan[1] = 3; stall_plan[2] = 3;
        for (int i = 0; i < BEATS; i++) stall_used[i] = 0;
        issue(3'd1, 2'd2, {32'd50, 32'd40, 32'd30, 32'd20}, {32'd5, 32'd50, 32'd10, 32'd25}, s);
        wait_done(s, lat, dcyc, reqs, e);
        chk("stall_lat", VLEN'(lat), VLEN'(11));
        chk("stall_reqs", VLEN'(reqs), VLEN'(10));
        chk("stall_res", result, 128'h0000002D_FFFFFFF6_00000014_FFFFFFFB);
        stall_plan[1] = 0; stall_plan[2] = 0;

        // Illegal vop, then illegal format
        issue(3'b110, 2'd2, {4{32'hDEADBEEF}}, {4{32'h1}}, s);
        wait_done(s, lat, dcyc, reqs, e);
        chk("ill_vop_lat", VLEN'(lat), VLEN'(1));
        chk("ill_vop_err", VLEN'(e), VLEN'(1));
        chk("ill_vop_reqs", VLEN'(reqs), VLEN'(0));
        chk("ill_vop_res", result, '0);
        issue(3'd0, 2'b11, {4{32'h12345678}}, {4{32'h1}}, s);
        wait_done(s, lat, dcyc, reqs, e);
        chk("ill_df_lat", VLEN'(lat), VLEN'(1));
        chk("ill_df_err", VLEN'(e), VLEN'(1));
        chk("ill_df_res", result, '0);

        // Flush in the middle of an orv
        issue(3'd3, 2'd0, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, s);
        found = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #1 start = 1'b0;
            if (m_phase == 1 && m_k == 2) begin
                found = 1; flush = 1'b1;
                break;
            end
        end
        chk("flush_reached", VLEN'(found), VLEN'(1));
        @(negedge clk);
        chk("flush_busy", VLEN'(busy), VLEN'(0));
        #1 flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("flush_nodone", VLEN'(done), VLEN'(0));
        end
        // flush and start together in IDLE: start dropped
        #1 flush = 1'b1; start = 1'b1; vop = 3'd0; df = 2'd2;
        @(negedge clk);
        chk("flush_start_busy", VLEN'(busy), VLEN'(0));
        #1 flush = 1'b0; start = 1'b0;
        issue(3'd2, 2'd2, {VLEN{1'b1}}, {16{8'h0F}}, s);
        wait_done(s, lat, dcyc, reqs, e);
        chk("andv_lat", VLEN'(lat), VLEN'(BEATS + 1));
        chk("andv_res", result, 128'h0F0F0F0F_0F0F0F0F_0F0F0F0F_0F0F0F0F);
        chk("andv_err", VLEN'(e), VLEN'(0));

        // Start while busy is ignored
        issue(3'd0, 2'd1, {8{16'h1111}}, {8{16'h0101}}, s);
        @(negedge clk);
        #1 start = 1'b1; vop = 3'd3; df = 2'd0; src_a = {VLEN{1'b1}}; src_b = {VLEN{1'b1}};
        @(negedge clk);
        #1 start = 1'b0;
        wait_done(s, lat, dcyc, reqs, e);
        chk("ign_lat", VLEN'(lat), VLEN'(BEATS + 1));
        chk("ign_res", result, {8{16'h1212}});

        // Async reset mid-RUN takes effect without a clock edge
        issue(3'd0, 2'd2, {4{32'h01010101}}, {4{32'h02020202}}, s);
        @(negedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", VLEN'(busy), VLEN'(0));
        chk("arst_req", VLEN'(alu_req), VLEN'(0));
        chk("arst_res", result, '0);
        @(negedge clk);
        chk("arst_done", VLEN'(done), VLEN'(0));
        #1 reset = 1'b0;

        // Back-to-back: next start in the cycle after done, then BEATS+1 latency
        issue(3'd4, 2'd0, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, s);
        wait_done(s, lat, d1, reqs, e);
        chk("b2b_lat1", VLEN'(lat), VLEN'(BEATS + 1));
        issue(3'd1, 2'd1, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, s);
        wait_done(s, lat, dcyc, reqs, e);
        chk("b2b_lat2", VLEN'(lat), VLEN'(BEATS + 1));
        chk("b2b_gap", VLEN'(dcyc - d1), VLEN'(1 + BEATS + 1));

        // Random ops, formats and grant pattern
        gnt_mode = 1;
        for (int n = 0; n < 40; n++) begin
            rop  = 3'($urandom_range(0, 7));
            rfmt = 2'($urandom_range(0, 3));
            ra = {$urandom, $urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 3) == 0) rb = ra;
            issue(rop, rfmt, ra, rb, s);
            wait_done(s, lat, dcyc, reqs, e);
            chk("rand_done", VLEN'(lat > 0), VLEN'(1));
            chk("rand_res", result, vec_op(ra, rb, rop, rfmt));
            chk("rand_err", VLEN'(e), VLEN'(!(rop <= 3'd4 && rfmt != 2'b11)));
        end
        gnt_mode = 0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
